// File: rtl/intrapred_pkg.sv
// Shared types and arithmetic for the intra-prediction / forward-transform path.
// butterfly4 works at a fixed wide width; callers pass the true operand width for sign extension.
package intrapred_pkg;

    localparam int unsigned RES_W_DEF  = 9;
    localparam int unsigned COEF_W_DEF = 16;
    localparam int unsigned BF_W       = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    typedef logic [3:0][BF_W-1:0] bf4_t;

    function automatic logic signed [BF_W-1:0] sext(input logic [BF_W-1:0] v, input int unsigned w);
        logic signed [BF_W-1:0] t;
        t = $signed(v << (BF_W - w));
        return t >>> (BF_W - w);
    endfunction

    // H.264 4-point forward core butterfly on w-bit signed inputs.
    function automatic bf4_t butterfly4(input bf4_t x, input int unsigned w);
        logic signed [BF_W-1:0] e0, e1, e2, e3;
        bf4_t h;
        e0 = sext(x[0], w) + sext(x[3], w);
        e1 = sext(x[1], w) + sext(x[2], w);
        e2 = sext(x[1], w) - sext(x[2], w);
        e3 = sext(x[0], w) - sext(x[3], w);
        h[0] = e0 + e1;
        h[1] = e3 + e3 + e2;
        h[2] = e0 - e1;
        h[3] = e3 - e2 - e2;
        return h;
    endfunction

endpackage

// File: rtl/fwdtrans_luma4x4_bank.sv
// One ping-pong bank: 4x4 grid of row-transformed values, blk tag and fill/drain state.
module fwdtrans_bank
    import intrapred_pkg::*;
#(
    parameter int unsigned H_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wr_en,
    input  logic [1:0]              i_wr_row,
    input  logic [3:0][H_W-1:0]     i_wr_data,
    input  logic [3:0]              i_wr_blk,
    input  logic                    i_rd_en,
    input  logic [1:0]              i_rd_row,
    output bank_state_e             o_state,
    output logic [3:0]              o_blk,
    output logic [3:0][3:0][H_W-1:0] o_data
);

    bank_state_e              r_state;
    bank_state_e              w_state_nxt;
    logic [3:0]               r_blk;
    logic [3:0][3:0][H_W-1:0] r_rows;

    // A new block's first row wins over the old block's last read on the same bank.
    always_comb begin
        w_state_nxt = r_state;
        if (i_wr_en) begin
            if (i_wr_row == 2'd0)      w_state_nxt = BANK_FILLING;
            else if (i_wr_row == 2'd3) w_state_nxt = BANK_FULL;
        end else if (i_rd_en) begin
            if (i_rd_row == 2'd0)      w_state_nxt = BANK_DRAINING;
            else if (i_rd_row == 2'd3) w_state_nxt = BANK_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BANK_EMPTY;
            r_blk   <= '0;
            r_rows  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_wr_en) begin
                r_rows[i_wr_row] <= i_wr_data;
                if (i_wr_row == 2'd0) r_blk <= i_wr_blk;
            end
        end
    end

    assign o_state = r_state;
    assign o_blk   = r_blk;
    assign o_data  = r_rows;

endmodule

// File: rtl/fwdtrans_luma4x4.sv
// Forward 4x4 luma core transform: row butterfly on entry into ping-pong banks,
// column butterfly on the draining bank selects the output row combinationally.
module fwdtrans_luma4x4
    import intrapred_pkg::*;
#(
    parameter int unsigned RES_W  = RES_W_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*RES_W-1:0]    in_row,
    input  logic [3:0]            in_blk,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*COEF_W-1:0]   out_coef,
    output logic [1:0]            out_row,
    output logic [3:0]            out_blk
);

    localparam int unsigned H_W = RES_W + 3;

    logic                     r_wbank, r_rbank;
    logic [1:0]               r_wrow, r_rrow;
    logic                     w_in_fire, w_out_fire;
    logic [3:0][RES_W-1:0]    w_in_samp;
    logic [3:0][H_W-1:0]      w_wr_data;
    logic [3:0][COEF_W-1:0]   w_coef;
    bank_state_e              w_state [2];
    logic [3:0]               w_blk   [2];
    logic [3:0][3:0][H_W-1:0] w_data  [2];

    assign w_in_samp  = in_row;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign in_ready   = !(w_state[r_wbank] inside {BANK_FULL, BANK_DRAINING});
    assign out_valid  = w_state[r_rbank] inside {BANK_FULL, BANK_DRAINING};
    assign out_coef   = w_coef;
    assign out_row    = r_rrow;
    assign out_blk    = w_blk[r_rbank];

    always_comb begin
        bf4_t v_x, v_h;
        v_x       = '0;
        w_wr_data = '0;
        for (int unsigned c = 0; c < 4; c++) v_x[2'(c)] = BF_W'(w_in_samp[2'(c)]);
        v_h = butterfly4(v_x, RES_W);
        for (int unsigned c = 0; c < 4; c++) w_wr_data[2'(c)] = v_h[2'(c)][H_W-1:0];
    end

    always_comb begin
        bf4_t v_col, v_y;
        v_col  = '0;
        v_y    = '0;
        w_coef = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned i = 0; i < 4; i++) v_col[2'(i)] = BF_W'(w_data[r_rbank][2'(i)][2'(c)]);
            v_y = butterfly4(v_col, H_W);
            w_coef[2'(c)] = v_y[r_rrow][COEF_W-1:0];
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fwdtrans_bank #(.H_W(H_W)) u_bank (
            .clk       (clk),
            .reset     (reset),
            .i_wr_en   (w_in_fire && (r_wbank == 1'(b))),
            .i_wr_row  (r_wrow),
            .i_wr_data (w_wr_data),
            .i_wr_blk  (in_blk),
            .i_rd_en   (w_out_fire && (r_rbank == 1'(b))),
            .i_rd_row  (r_rrow),
            .o_state   (w_state[b]),
            .o_blk     (w_blk[b]),
            .o_data    (w_data[b])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_wrow  <= '0;
            r_rrow  <= '0;
        end else begin
            if (w_in_fire) begin
                r_wrow <= r_wrow + 2'd1;
                if (r_wrow == 2'd3) r_wbank <= ~r_wbank;
            end
            if (w_out_fire) begin
                r_rrow <= r_rrow + 2'd1;
                if (r_rrow == 2'd3) r_rbank <= ~r_rbank;
            end
        end
    end

endmodule

// File: doc/fwdtrans_luma4x4.md
# fwdtrans_luma4x4

Forward 4x4 integer core transform for luma residuals, placed directly downstream of intra prediction. It accepts the winning-mode residual of one 4x4 block row by row and applies the H.264 row butterfly on entry. It then emits the 2-D transform coefficients row by row to the quantiser. Two ping-pong banks let the next block be accepted while the current one drains.

## Interface
- `RES_W`, default 9: signed residual sample width.
- `COEF_W`, default 16: signed coefficient width; must be ≥ RES_W+7.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input row valid.
- `in_ready` out 1: the block can accept an input row.
- `in_row` in 4*RES_W: residual row, sample c at bits [c*RES_W +: RES_W], two's complement.
- `in_blk` in 4: 4x4 block index within the MB; sampled with row 0 only.
- `out_valid` out 1: output coefficient row valid.
- `out_ready` in 1: the downstream stage accepts the output row.
- `out_coef` out 4*COEF_W: coefficient row Y[r][0..3], same packing as `in_row`.
- `out_row` out 2: output row index r.
- `out_blk` out 4: block index of the draining bank.

## Operation
- Handshakes: an input transfer happens when `in_valid && in_ready`; an output transfer happens when `out_valid && out_ready`. Row order is 0..3 on both sides.
- Row butterfly on each accepted row x:
  - e0=x0+x3, e1=x1+x2, e2=x1−x2, e3=x0−x3.
  - h0=e0+e1, h1=2·e3+e2, h2=e0−e1, h3=e3−2·e2.
  - h is stored at RES_W+3 bits signed.
- Column butterfly: the same equations are applied to each stored column c (h[0..3][c]), giving Y[0..3][c] at COEF_W bits with sign extension. Output row r carries Y[r][0..3].
- Banks: two banks, each holding a 4x4 grid of RES_W+3-bit values, a 4-bit blk tag and a `full` flag.
  - Write side: `wbank` pointer plus a 2-bit `wrow` counter.
  - Read side: `rbank` pointer plus a 2-bit `rrow` counter.
- Per-bank state machine EMPTY → FILLING → FULL → DRAINING → EMPTY:
  - EMPTY→FILLING on the row-0 input transfer.
  - FILLING→FULL on the row-3 input transfer; `wbank` toggles.
  - FULL→DRAINING on the row-0 output transfer.
  - DRAINING→EMPTY on the row-3 output transfer; `rbank` toggles.
- `in_ready` = bank[`wbank`] is not FULL or DRAINING.
- `out_valid` = bank[`rbank`] is FULL or DRAINING.
- `out_coef` is computed combinationally from bank[`rbank`] and `rrow`.
- Simultaneous events: an input transfer and an output transfer in the same cycle, on different banks, both take effect. When the last output row and the first input row hit the same bank in the same cycle, the bank goes DRAINING→FILLING.
- Wrap-around: the `wrow` and `rrow` counters wrap 3→0.
- No partial-block abort. An `in_valid` deassertion mid-block simply stalls `wrow`.
- Reset mid-operation: all bank contents are discarded.

## Timing
- Reset values: both banks EMPTY, `wbank`=`rbank`=0, `wrow`=`rrow`=0, `in_ready`=1, `out_valid`=0, `out_coef`=0, `out_row`=0, `out_blk`=0.
- Latency: the row-3 input transfer in cycle N gives `out_valid`=1 with row 0 in cycle N+1.
- Throughput: 1 row per cycle each side. Steady state is one block per 4 cycles with no bubbles while `out_ready`=1.
- Stall limit: with `out_ready` held low, exactly 8 input rows (2 blocks) are accepted, then `in_ready`=0.
- Stability: `out_coef`, `out_row` and `out_blk` must hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `intrapred_pkg`:
  - `RES_W` and `COEF_W` defaults.
  - Bank state enum.
  - A `butterfly4` function, parameterised by input width, used for both passes.
- Optional sub-module `fwdtrans_bank`: one bank's storage, state machine and blk tag, instantiated twice. The top level holds the pointers, the row butterfly and the column-butterfly mux.

## Test plan
- All samples = 10, `in_blk`=5, `out_ready`=1 → row 0 = {160,0,0,0}, rows 1–3 all 0, `out_blk`=5, `out_valid` rising the cycle after the row-3 transfer.
- Single sample x[0][0]=1, rest 0 → Y[r][c]=v[r]·v[c] with v={1,2,1,1}; row 1 = {2,4,2,2}.
- Worst case X[i][j]=255·s_i·s_j with s={1,1,−1,−1}:
  - Y[1][1] = 9180, Y[1][3] = −3060, Y[3][3] = 1020.
  - All samples −255 → Y[0][0] = −4080, with no overflow.
- `out_ready`=0, 12 rows offered → 8 accepted and `in_ready`=0. Then `out_ready`=1 → blocks drain in order with correct blk tags, and `in_ready` returns the cycle after the first bank's row-3 output transfer.
- Random `in_valid` and `out_ready` over 1000 blocks → coefficients match the reference model, with no loss, duplication or reordering.
- `reset` asserted with one bank FULL and the other FILLING → the next cycle shows `out_valid`=0 and `in_ready`=1; the next block completes normally.
